// File: rtl/alu_mdu_seq.sv
// Sequential RV32I ALU with an iterative RV32M multiply/divide unit.
// Results leave through a valid/ready handshake.
module alu_mdu_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MDU_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            ALUctrl,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  Zero,
  output logic                  busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned SW = $clog2(W);
  localparam int unsigned CW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  acc_q, acc_d, lo_q, lo_d, opb_q, opb_d;
  logic          neg_q, neg_d, rneg_q, rneg_d;
  logic [W-1:0]  res_q, res_d;
  logic          zero_q, zero_d, rdy_q, rdy_d, vld_q, vld_d, busy_q, busy_d;

  logic [SW-1:0] shamt;
  logic [W-1:0]  base_res;
  logic          is_m, div_zero, div_ovf, spec, a_sgn, b_sgn;
  logic [W-1:0]  a_mag, b_mag, spec_res;
  logic [W:0]    mul_sum, div_rs, div_trial;
  logic          div_ge;
  logic [W-1:0]  acc_n, lo_n, quo_s, rem_s, mdu_res;
  logic [2*W-1:0] prod, prod_s;

  assign shamt = ALUop2[SW-1:0];

  // Single-cycle base ops; any code not listed (and gated M codes) gives 0.
  always_comb begin
    base_res = '0;
    case (ALUctrl)
      5'b00000: base_res = ALUop1 + ALUop2;
      5'b00001: base_res = ALUop1 - ALUop2;
      5'b00010: base_res = ALUop1 << shamt;
      5'b00011: base_res = W'($signed(ALUop1) < $signed(ALUop2));
      5'b00100: base_res = ALUop1 ^ ALUop2;
      5'b00101: base_res = ALUop1 >> shamt;
      5'b00110: base_res = ALUop1 | ALUop2;
      5'b00111: base_res = ALUop1 & ALUop2;
      5'b01000: base_res = W'(ALUop1 < ALUop2);
      5'b01101: base_res = W'($signed(ALUop1) >>> shamt);
      default:  base_res = '0;
    endcase
  end

  // Accept-time decode: M-op detection, divide special cases, operand magnitudes.
  always_comb begin
    is_m     = MDU_EN && (ALUctrl[4:3] == 2'b10);
    div_zero = (ALUop2 == '0);
    div_ovf  = !ALUctrl[0] && (ALUop1 == MIN_NEG) && (ALUop2 == '1);
    spec     = is_m && ALUctrl[2] && (div_zero || div_ovf);
    if (div_zero) spec_res = ALUctrl[1] ? ALUop1 : '1;
    else          spec_res = ALUctrl[1] ? '0 : ALUop1;
    a_sgn = ALUop1[W-1] && (ALUctrl[2:0] inside {3'b001, 3'b010, 3'b100, 3'b110});
    b_sgn = ALUop2[W-1] && (ALUctrl[2:0] inside {3'b001, 3'b100, 3'b110});
    a_mag = a_sgn ? -ALUop1 : ALUop1;
    b_mag = b_sgn ? -ALUop2 : ALUop2;
  end

  // One shift-add multiply or restoring-divide step, plus sign fix-up of the result.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_rs    = {acc_q, lo_q[W-1]};
    div_trial = div_rs - {1'b0, opb_q};
    div_ge    = !div_trial[W];
    if (op_q[2]) begin
      acc_n = div_ge ? div_trial[W-1:0] : div_rs[W-1:0];
      lo_n  = {lo_q[W-2:0], div_ge};
    end else begin
      acc_n = mul_sum[W:1];
      lo_n  = {mul_sum[0], lo_q[W-1:1]};
    end
    prod   = {acc_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_n : lo_n;
    rem_s  = rneg_q ? -acc_n : acc_n;
    if (op_q[2])               mdu_res = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'b00) mdu_res = prod_s[W-1:0];
    else                       mdu_res = prod_s[2*W-1:W];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    zero_d  = zero_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          if (is_m && !spec) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            op_d    = ALUctrl[2:0];
            acc_d   = '0;
            neg_d   = a_sgn ^ b_sgn;
            rneg_d  = a_sgn;
            lo_d    = ALUctrl[2] ? a_mag : b_mag;
            opb_d   = ALUctrl[2] ? b_mag : a_mag;
          end else begin
            state_d = S_DONE;
            res_d   = spec ? spec_res : base_res;
            zero_d  = (res_d == '0);
          end
        end
        S_BUSY: begin
          acc_d = acc_n;
          lo_d  = lo_n;
          cnt_d = CW'(cnt_q + 1'b1);
          if (cnt_q == CW'(W - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
            res_d   = mdu_res;
            zero_d  = (mdu_res == '0);
          end
        end
        S_DONE:  if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    rdy_d  = (state_d == S_IDLE);
    vld_d  = (state_d == S_DONE);
    busy_d = (state_d == S_BUSY);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign ALUout    = res_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Randomized and directed bench for alu_mdu_seq against a plain-arithmetic model.
module tb_alu_mdu_seq;

  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, Zero, busy;
  logic [4:0]  ALUctrl;
  logic [31:0] ALUop1, ALUop2, ALUout;

  int n_cmp = 0;
  int n_err = 0;

  alu_mdu_seq #(.DATA_WIDTH(32), .MDU_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUctrl(ALUctrl), .ALUop1(ALUop1), .ALUop2(ALUop2), .out_valid(out_valid),
    .out_ready(out_ready), .ALUout(ALUout), .Zero(Zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference result straight from the arithmetic definition of each op.
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    logic [4:0]      sh = b[4:0];
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << sh;
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return a ^ b;
      5'd5:  return a >> sh;
      5'd6:  return a | b;
      5'd7:  return a & b;
      5'd8:  return (ua < ub) ? 32'd1 : 32'd0;
      5'd13: return 32'(sa >>> sh);
      5'd16: return 32'(ua * ub);
      5'd17: return 32'((sa * sb) >>> 32);
      5'd18: return 32'((sa * longint'(ub)) >>> 32);
      5'd19: return 32'((ua * ub) >> 32);
      5'd20: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      5'd22: return (b == 0) ? a : 32'(sa % sb);
      5'd23: return (b == 0) ? a : 32'(ua % ub);
      default: return 32'd0;
    endcase
  endfunction

  // Expected accept-to-valid latency in cycles.
  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 5'd16 || op > 5'd23) return 1;
    if (op >= 5'd20 && b == 0) return 1;
    if ((op == 5'd20 || op == 5'd22) && a == MIN && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, scramble inputs after accept, wait for the result and consume it.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic z,
                       output logic rdy_bad, output int bcnt, output logic vld_after);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    ALUctrl = op; ALUop1 = a; ALUop2 = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; ALUctrl = 5'($urandom); ALUop1 = $urandom; ALUop2 = $urandom;
    lat = 1; rdy_bad = 1'b0; bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_bad = 1'b1;
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    res = ALUout; z = Zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vld_after = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUctrl = '0; ALUop1 = '0; ALUop2 = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (ALUout !== 32'd0)   begin n_err++; $display("FAIL reset_aluout got %h want 0", ALUout); end
    n_cmp++; if (Zero !== 1'b0)      begin n_err++; $display("FAIL reset_zero got %b want 0", Zero); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [4:0]  ops [10] = '{5'd0, 5'd1, 5'd13, 5'd17, 5'd19, 5'd20, 5'd21, 5'd22, 5'd5, 5'd31};
    logic [31:0] as  [10] = '{32'h7FFF_FFFF, 32'd5, MIN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MIN,
                              32'd1234, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs  [10] = '{32'd1, 32'd5, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd0, 32'd2, 32'd31, 32'd9};
    logic [31:0] exp [10] = '{MIN, 32'd0, 32'hF800_0000, 32'd0, 32'hFFFF_FFFE, MIN,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0};
    int          elat[10] = '{1, 1, 1, 33, 33, 1, 1, 33, 1, 1};
    int lat, bcnt; logic [31:0] res; logic z, rb, va;
    for (int i = 0; i < 10; i++) begin
      do_op(ops[i], as[i], bs[i], lat, res, z, rb, bcnt, va);
      n_cmp++; if (res !== exp[i]) begin n_err++; $display("FAIL dir%0d_result got %h want %h", i, res, exp[i]); end
      n_cmp++; if (z !== (exp[i] == 0)) begin n_err++; $display("FAIL dir%0d_zero got %b want %b", i, z, exp[i] == 0); end
      n_cmp++; if (lat != elat[i]) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, elat[i]); end
      n_cmp++; if (rb !== 1'b0) begin n_err++; $display("FAIL dir%0d_in_ready_while_busy got 1 want 0", i); end
      n_cmp++; if (bcnt != elat[i] - 1) begin n_err++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bcnt, elat[i] - 1); end
      n_cmp++; if (va !== 1'b0) begin n_err++; $display("FAIL dir%0d_valid_after_take got %b want 0", i, va); end
    end
  endtask

  task automatic test_random();
    logic [4:0] legal [18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd13,
                               5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};
    logic [4:0] op; logic [31:0] a, b, e, res; logic z, rb, va; int lat, bcnt, el;
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : legal[$urandom_range(0, 17)];
      a = pick_opnd(); b = pick_opnd();
      e = ref_res(op, a, b); el = ref_lat(op, a, b);
      do_op(op, a, b, lat, res, z, rb, bcnt, va);
      n_cmp++; if (res !== e) begin n_err++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, e); end
      n_cmp++; if (z !== (e == 0)) begin n_err++; $display("FAIL rnd%0d_zero got %b want %b", i, z, e == 0); end
      n_cmp++; if (lat != el) begin n_err++; $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", i, op, lat, el); end
      n_cmp++; if (bcnt != el - 1 || rb !== 1'b0) begin
        n_err++; $display("FAIL rnd%0d_busy_ready busy=%0d rdy_bad=%b want %0d/0", i, bcnt, rb, el - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ALUctrl = 5'd0; ALUop1 = 32'h10; ALUop2 = 32'h20; in_valid = 1'b1;
    @(negedge clk);
    ALUctrl = 5'd1; ALUop1 = 32'd9; ALUop2 = 32'd4;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp%0d_out_valid got %b want 1", i, out_valid); end
      n_cmp++; if (ALUout !== 32'h30) begin n_err++; $display("FAIL bp%0d_aluout got %h want 30", i, ALUout); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp%0d_in_ready got %b want 0", i, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    n_cmp++; if (ALUout !== 32'h30)  begin n_err++; $display("FAIL bp_release_aluout got %h want 30", ALUout); end
  endtask

  task automatic test_flush();
    int seen; int lat, bcnt; logic [31:0] res; logic z, rb, va;
    @(negedge clk);
    ALUctrl = 5'd21; ALUop1 = 32'd1000000; ALUop2 = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy got %b want 1", busy); end
    flush = 1'b1; in_valid = 1'b1; ALUctrl = 5'd0; ALUop1 = 32'd1; ALUop2 = 32'd1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) seen++; end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL flush_no_pulse got %0d valid cycles want 0", seen); end
    // in_valid coinciding with flush in IDLE must be dropped
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_idle_accept got %b want 0", out_valid); end
    do_op(5'd0, 32'd2, 32'd3, lat, res, z, rb, bcnt, va);
    n_cmp++; if (res !== 32'd5) begin n_err++; $display("FAIL flush_add_result got %h want 5", res); end
    n_cmp++; if (lat != 1)      begin n_err++; $display("FAIL flush_add_latency got %0d want 1", lat); end
    // flush while a result is held
    ALUctrl = 5'd0; ALUop1 = 32'd7; ALUop2 = 32'd8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_done_out_valid got %b want 0", out_valid); end
    n_cmp++; if (ALUout !== 32'd15)  begin n_err++; $display("FAIL flush_done_aluout got %h want f", ALUout); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt; logic [31:0] res; logic z, rb, va;
    do_op(5'd0, 32'd2, 32'd3, lat, res, z, rb, bcnt, va);
    ALUctrl = 5'd20; ALUop1 = 32'd5000; ALUop2 = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    n_cmp++; if (ALUout !== 32'd0)   begin n_err++; $display("FAIL rstmid_aluout got %h want 0", ALUout); end
    n_cmp++; if (Zero !== 1'b0)      begin n_err++; $display("FAIL rstmid_zero got %b want 0", Zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_release_in_ready got %b want 1", in_ready); end
    repeat (40) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_stale_result got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
